// File: rtl/design_mux_gen.sv
// Hosts NUM_DESIGNS user designs behind one pad bank; a Wishbone register file selects
// the active design, and every switch holds all designs in reset with tri-stated pads.
module design_mux_gen #(
  parameter int          NUM_DESIGNS = 8,
  parameter int          IO_W        = 36,
  parameter int          SETTINGS_W  = 32,
  parameter int          RST_HOLD    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic [NUM_DESIGNS-1:0]      design_rst_n,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_out,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_oeb,
  output logic [IO_W-1:0]             io_out,
  output logic [IO_W-1:0]             io_oeb,
  output logic [SETTINGS_W-1:0]       custom_settings,
  output logic [31:0]                 status_o
);

  localparam int SEL_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
  localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_OFF, S_HOLD, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [7:0]            r_sel;
  logic                  r_en;
  logic                  r_err;
  logic [15:0]           r_switch_cnt;
  logic [SETTINGS_W-1:0] r_settings;
  logic                  r_ack;
  logic [31:0]           r_dat;

  logic                  w_req;
  logic                  w_acc;
  logic                  w_sel_wr;
  logic                  w_set_wr;
  logic                  w_srst_wr;
  logic                  w_idx_ok;
  logic                  w_release;
  logic [31:0]           w_status;
  logic [31:0]           w_settings_ext;
  logic [31:0]           w_rdata;
  logic [SETTINGS_W-1:0] w_settings_new;
  logic [SEL_W-1:0]      w_sel_idx;
  logic [IO_W-1:0]       w_slice_out [NUM_DESIGNS];
  logic [IO_W-1:0]       w_slice_oeb [NUM_DESIGNS];
  logic                  w_unused;

  // A new request is only accepted while ack is low, so held strobes get every other cycle.
  assign w_req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_acc     = w_req && !r_ack;
  assign w_sel_wr  = w_acc && wbs_we_i && (wbs_adr_i[3:2] == 2'd0);
  assign w_set_wr  = w_acc && wbs_we_i && (wbs_adr_i[3:2] == 2'd1);
  assign w_srst_wr = w_acc && wbs_we_i && (wbs_adr_i[3:2] == 2'd3);
  assign w_idx_ok  = ({24'd0, wbs_dat_i[7:0]} < 32'(NUM_DESIGNS));
  assign w_unused  = &{1'b0, wbs_adr_i[1:0], wbs_dat_i};

  assign w_sel_idx = r_sel[SEL_W-1:0];
  assign w_status  = {r_switch_cnt, 5'd0, r_err, (r_state == S_HOLD), r_en, r_sel};
  assign w_release = (r_state == S_HOLD) && (w_state_next == S_RUN);

  always_comb begin
    w_settings_ext = '0;
    w_settings_ext[SETTINGS_W-1:0] = r_settings;
  end

  generate
    for (genvar gi = 0; gi < SETTINGS_W; gi++) begin : g_set_bit
      assign w_settings_new[gi] = wbs_sel_i[gi/8] ? wbs_dat_i[gi] : r_settings[gi];
    end
    for (genvar gi = 0; gi < NUM_DESIGNS; gi++) begin : g_design
      assign w_slice_out[gi]  = design_io_out[gi*IO_W +: IO_W];
      assign w_slice_oeb[gi]  = design_io_oeb[gi*IO_W +: IO_W];
      assign design_rst_n[gi] = (r_state == S_RUN) && (w_sel_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    w_rdata = {23'd0, r_en, r_sel};
      2'd1:    w_rdata = w_settings_ext;
      2'd2:    w_rdata = w_status;
      default: w_rdata = '0;
    endcase
  end

  // Register writes override the running hold count; a SEL write mid-hold restarts it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == S_HOLD) begin
      if (r_cnt == CNT_LAST) begin
        w_state_next = S_RUN;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
    if (w_sel_wr) begin
      if (!w_idx_ok || !wbs_dat_i[8]) begin
        w_state_next = S_OFF;
      end else begin
        w_state_next = S_HOLD;
        w_cnt_next   = '0;
      end
    end else if (w_srst_wr && (r_state == S_RUN)) begin
      w_state_next = S_HOLD;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sel        <= '0;
      r_en         <= 1'b0;
      r_err        <= 1'b0;
      r_switch_cnt <= '0;
      r_settings   <= '0;
      r_ack        <= 1'b0;
      r_dat        <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wbs_we_i) ? w_rdata : 32'd0;
      if (w_sel_wr) begin
        if (!w_idx_ok) begin
          r_en  <= 1'b0;
          r_err <= 1'b1;
        end else begin
          r_sel <= wbs_dat_i[7:0];
          r_en  <= wbs_dat_i[8];
          r_err <= 1'b0;
        end
      end
      if (w_set_wr) r_settings <= w_settings_new;
      if (w_release) r_switch_cnt <= r_switch_cnt + 16'd1;
    end
  end

  assign io_out          = (r_state == S_RUN) ? w_slice_out[w_sel_idx] : '0;
  assign io_oeb          = (r_state == S_RUN) ? w_slice_oeb[w_sel_idx] : '1;
  assign wbs_ack_o       = r_ack;
  assign wbs_dat_o       = r_dat;
  assign custom_settings = r_settings;
  assign status_o        = w_status;

endmodule

// File: tb/tb_design_mux_gen.sv
// Directed-plus-random bench for design_mux_gen; a cycle-stamped model predicts mode,
// release times, registers and pad routing.
module tb_design_mux_gen;

  localparam int N = 8;
  localparam int W = 36;
  localparam int HOLD = 16;
  localparam int M_OFF = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]    sel_i = '0;
  logic [31:0]   adr_i = '0, dat_i = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [N-1:0]  rst_n;
  logic [N*W-1:0] d_out = '0, d_oeb = '0;
  logic [W-1:0]  io_out, io_oeb;
  logic [31:0]   settings;
  logic [31:0]   status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode plus the absolute cycle at which a pending hold finishes.
  int          m_mode;
  int          m_rel;
  logic [7:0]  m_sel;
  logic        m_en, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_set;

  design_mux_gen dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i),
    .wbs_we_i(we_i), .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .design_rst_n(rst_n),
    .design_io_out(d_out), .design_io_oeb(d_oeb), .io_out(io_out), .io_oeb(io_oeb),
    .custom_settings(settings), .status_o(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_rel = 0; m_sel = '0; m_en = 1'b0; m_err = 1'b0;
    m_cnt = '0; m_set = '0;
  endtask

  task automatic settle(input int t);
    if (m_mode == M_HOLD && t >= m_rel) begin
      m_mode = M_RUN;
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_cnt, 5'd0, m_err, (m_mode == M_HOLD), m_en, m_sel};
  endfunction

  // Applies a write accepted on clock edge e (sees the state of cycle e-1).
  task automatic model_write(input int e, input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] bs);
    settle(e - 1);
    case (a[3:2])
      2'd0: begin
        if (int'(d[7:0]) >= N) begin
          m_mode = M_OFF; m_en = 1'b0; m_err = 1'b1;
        end else if (!d[8]) begin
          m_mode = M_OFF; m_en = 1'b0; m_err = 1'b0; m_sel = d[7:0];
        end else begin
          m_mode = M_HOLD; m_rel = e + HOLD; m_en = 1'b1; m_err = 1'b0; m_sel = d[7:0];
        end
      end
      2'd1: for (int b = 0; b < 4; b++) if (bs[b]) m_set[8*b +: 8] = d[8*b +: 8];
      2'd3: if (m_mode == M_RUN) begin m_mode = M_HOLD; m_rel = e + HOLD; end
      default: ;
    endcase
  endtask

  task automatic check_state();
    logic [N-1:0] e_rst;
    logic [W-1:0] e_out, e_oeb;
    for (int k = 0; k < N*W; k++) begin
      d_out[k] = 1'($urandom_range(0, 1));
      d_oeb[k] = 1'($urandom_range(0, 1));
    end
    #1;
    settle(cyc);
    e_rst = '0; e_out = '0; e_oeb = '1;
    if (m_mode == M_RUN) begin
      e_rst[m_sel] = 1'b1;
      e_out = d_out[int'(m_sel)*W +: W];
      e_oeb = d_oeb[int'(m_sel)*W +: W];
    end
    check("design_rst_n", 64'(rst_n), 64'(e_rst));
    check("io_out", 64'(io_out), 64'(e_out));
    check("io_oeb", 64'(io_oeb), 64'(e_oeb));
    check("status_o", 64'(status), 64'(m_status()));
    check("custom_settings", 64'(settings), 64'(m_set));
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] bs);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = bs;
    adr_i = 32'h3000_0000 | 32'(a); dat_i = d;
    @(posedge clk);
    @(negedge clk);
    check("wr_ack_rise", 64'(ack), 64'd1);
    if (ack) model_write(cyc, a, d, bs);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    check("wr_ack_fall", 64'(ack), 64'd0);
  endtask

  task automatic wb_read(input logic [3:0] a);
    logic [31:0] e;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hf;
    adr_i = 32'h3000_0000 | 32'(a);
    @(posedge clk);
    @(negedge clk);
    check("rd_ack_rise", 64'(ack), 64'd1);
    settle(cyc - 1);
    case (a[3:2])
      2'd0: e = {23'd0, m_en, m_sel};
      2'd1: e = m_set;
      2'd2: e = m_status();
      default: e = 32'd0;
    endcase
    check("rd_data", 64'(dat_o), 64'(e));
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    check("rd_ack_fall", 64'(ack), 64'd0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_state();
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rs;
    int          idx;
    model_reset();
    repeat (3) @(negedge clk);
    check_state();
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_dat", 64'(dat_o), 64'd0);
    rst = 1'b0;

    wb_read(4'h8);
    run_cycles(3);

    wb_write(4'h0, 32'h103, 4'hf);
    run_cycles(HOLD + 2);
    check("status_run3", 64'(status), 64'h0001_0103);

    wb_write(4'h0, 32'h105, 4'hf);
    run_cycles(8);
    wb_write(4'h0, 32'h105, 4'hf);
    run_cycles(HOLD + 4);
    check("switch_cnt_once", 64'(status[31:16]), 64'd2);

    wb_write(4'h0, 32'h10A, 4'hf);
    check_state();
    check("err_bit", 64'(status[10]), 64'd1);
    wb_write(4'hC, 32'h0, 4'hf);
    run_cycles(3);
    wb_write(4'h0, 32'h100, 4'hf);
    run_cycles(HOLD + 2);

    wb_write(4'h4, 32'h0, 4'hf);
    wb_write(4'h4, 32'hDEAD_BEEF, 4'b0101);
    check("settings_bytes", 64'(settings), 64'h00AD_00EF);
    check_state();
    for (int i = 0; i < 4; i++) begin
      rd = $urandom();
      rs = 4'($urandom_range(0, 15));
      wb_write(4'h4, rd, rs);
      wb_read(4'h4);
      check_state();
    end

    for (int i = 0; i < 4; i++) begin
      idx = $urandom_range(0, N - 1);
      wb_write(4'h0, 32'h100 | 32'(idx), 4'hf);
      run_cycles($urandom_range(1, HOLD + 6));
      wb_read(4'h0);
    end

    wb_write(4'h0, 32'h102, 4'hf);
    run_cycles(HOLD + 1);
    wb_write(4'hC, $urandom(), 4'hf);
    run_cycles(HOLD + 3);
    wb_read(4'hC);
    wb_read(4'h8);

    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("miss_no_ack", 64'(ack), 64'd0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;

    wb_write(4'h0, 32'h104, 4'hf);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_state();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    rst = 1'b0;
    run_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
